// File: rtl/fft_pingpong_ram.sv
// Two-bank ping-pong frame buffer between an FFT producer and consumer.
// Define FFT_PINGPONG_BITREV_EN to bit-reverse write addresses (natural in, bit-reversed out).
module fft_pingpong_ram #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 6
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic              wr_commit_i,
   output logic              wr_ready_o,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o,
   output logic              rd_valid_o,
   input  logic              rd_release_i,
   output logic              rd_ready_o,
   output logic [1:0]        frames_o,
   output logic              err_o
);

   localparam int N = 1 << ADDR_W;

   logic [WIDTH-1:0]  mem_q [2*N];
   logic [1:0]        full_q, full_d;
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic              err_q, err_d;
   logic              rd_valid_q;
   logic [WIDTH-1:0]  rd_data_q;
   logic [ADDR_W-1:0] waddr;
   logic              wr_ok, rd_ok;
   logic              wr_fire, commit_fire, rd_fire, release_fire;

`ifdef FFT_PINGPONG_BITREV_EN
   function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] r;
      for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
      return r;
   endfunction
   assign waddr = bitrev(wr_addr_i);
`else
   assign waddr = wr_addr_i;
`endif

   assign wr_ok        = ~full_q[wr_bank_q];
   assign rd_ok        = full_q[rd_bank_q];
   assign wr_fire      = wr_en_i & wr_ok;
   assign commit_fire  = wr_commit_i & wr_ok;
   assign rd_fire      = rd_en_i & rd_ok;
   assign release_fire = rd_release_i & rd_ok;

   assign wr_ready_o = wr_ok;
   assign rd_ready_o = rd_ok;
   assign frames_o   = {1'b0, full_q[0]} + {1'b0, full_q[1]};
   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;
   assign err_o      = err_q;

   // A legal commit and release always hit different banks, so both bit updates compose.
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      if (commit_fire) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = ~wr_bank_q;
      end
      if (release_fire) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end
      err_d = err_q
            | (~wr_ok & (wr_en_i | wr_commit_i))
            | (~rd_ok & (rd_en_i | rd_release_i));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         full_q     <= 2'b00;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         full_q     <= full_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         err_q      <= err_d;
         rd_valid_q <= rd_fire;
         if (rd_fire) rd_data_q <= mem_q[{rd_bank_q, rd_addr_i}];
      end
   end

   // Storage is not reset; stale contents stay hidden until a bank is recommitted.
   always_ff @(posedge clk_i) begin
      if (wr_fire && !reset_i) mem_q[{wr_bank_q, waddr}] <= wr_data_i;
   end

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Scoreboard bench for fft_pingpong_ram: reads push expected data, a negedge monitor pops on rd_valid.
module tb_fft_pingpong_ram;

`ifdef FFT_PINGPONG_BITREV_EN
   localparam bit BR = 1'b1;
`else
   localparam bit BR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, wr_en, wr_commit, wr_ready, rd_en, rd_release, rd_ready, rd_valid, err;
   logic [5:0]  wr_addr, rd_addr;
   logic [31:0] wr_data, rd_data;
   logic [1:0]  frames;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   fft_pingpong_ram #(.WIDTH(32), .ADDR_W(6)) dut (
      .clk_i(clk), .reset_i(reset),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .wr_commit_i(wr_commit), .wr_ready_o(wr_ready),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
      .rd_release_i(rd_release), .rd_ready_o(rd_ready),
      .frames_o(frames), .err_o(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every rd_valid must match the oldest outstanding read.
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rd_unexpected: got rd_valid=1 data 0x%08h expected no read", rd_data);
         end else begin
            chk("rd_data", rd_data, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0; reset = 0;
      wr_addr = '0; wr_data = '0; rd_addr = '0;
   endtask

   // Write base+k at address k for all 64 addresses, committing on the last write.
   task automatic fill(input logic [31:0] base);
      for (int k = 0; k < 64; k++) begin
         wr_en = 1; wr_addr = 6'(k); wr_data = base + 32'(k); wr_commit = (k == 63);
         step();
      end
      wr_en = 0; wr_commit = 0;
   endtask

   task automatic rd(input logic [5:0] a, input logic [31:0] exp);
      rd_en = 1; rd_addr = a;
      exp_q.push_back(exp);
      step();
      rd_en = 0;
   endtask

   task automatic status(input string tag, input logic wr_r, input logic rd_r,
                         input logic [1:0] fr, input logic e);
      chk({tag, "_wr_ready"}, 32'(wr_ready), 32'(wr_r));
      chk({tag, "_rd_ready"}, 32'(rd_ready), 32'(rd_r));
      chk({tag, "_frames"},   32'(frames),   32'(fr));
      chk({tag, "_err"},      32'(err),      32'(e));
   endtask

   initial begin
      idle();
      reset = 1;
      step(); step();
      reset = 0;
      status("reset", 1, 1'b0, 2'd0, 0);
      chk("reset_rd_valid", 32'(rd_valid), 0);
      chk("reset_rd_data", rd_data, 0);

      // Bank0 <- k, then read back from it.
      fill(32'h0);
      status("fill0", 1, 1, 2'd1, 0);
      rd(6'd5,  BR ? 32'h28 : 32'h05);
      rd(6'd0,  32'h0);
      rd(6'd1,  BR ? 32'h20 : 32'h01);
      step();

      // Fill bank1; on its last write commit it while releasing bank0 and reading addr 63.
      for (int k = 0; k < 64; k++) begin
         wr_en = 1; wr_addr = 6'(k); wr_data = 32'h100 + 32'(k);
         if (k == 63) begin
            wr_commit = 1; rd_release = 1; rd_en = 1; rd_addr = 6'd63;
            exp_q.push_back(32'h3F);
         end
         step();
      end
      idle();
      status("swap", 1, 1, 2'd1, 0);
      rd(6'd5, BR ? 32'h128 : 32'h105);

      // Refill bank0 so both banks are full, then attempt illegal writes.
      fill(32'h200);
      status("both_full", 1'b0, 1, 2'd2, 0);
      wr_en = 1; wr_addr = 6'd5; wr_data = 32'hDEADBEEF; wr_commit = 1;
      step();
      idle();
      status("ill_wr", 1'b0, 1, 2'd2, 1);
      rd(6'd5, BR ? 32'h128 : 32'h105);
      rd_release = 1; step(); rd_release = 0;
      status("rel1", 1, 1, 2'd1, 1);
      rd(6'd5, BR ? 32'h228 : 32'h205);
      rd_release = 1; step(); rd_release = 0;
      status("rel0", 1, 1'b0, 2'd0, 1);
      rd_en = 1; rd_addr = 6'd5; step(); rd_en = 0;
      chk("ill_rd_valid", 32'(rd_valid), 0);
      chk("ill_rd_hold", rd_data, BR ? 32'h228 : 32'h205);

      // Reset mid-fill, with a commit asserted alongside it.
      reset = 1; step(); reset = 0;
      chk("clr_err", 32'(err), 0);
      for (int k = 0; k < 30; k++) begin
         wr_en = 1; wr_addr = 6'(k); wr_data = 32'h300 + 32'(k);
         step();
      end
      reset = 1; wr_commit = 1;
      step();
      idle();
      status("midreset", 1, 1'b0, 2'd0, 0);
      chk("midreset_rd_valid", 32'(rd_valid), 0);

      // Read with no frames available.
      rd_en = 1; rd_addr = 6'd5; step(); rd_en = 0;
      chk("empty_rd_valid", 32'(rd_valid), 0);
      chk("empty_err", 32'(err), 1);
      chk("empty_rd_data", rd_data, 0);
      step(); step();
      chk("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
